// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the 32 x 16-bit data memory.
// Each transaction runs IDLE (grant) -> ACCESS (memory cycle) -> DONE (ack pulse).
module dmem_arbiter #(
   parameter int unsigned AW         = 5,
   parameter int unsigned DW         = 16,
   parameter bit          FIXED_PRIO = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e        state_q, state_d;
   logic          mem_write_q, mem_write_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          last_grant_q, last_grant_d;
   logic          grant_id_q, grant_id_d;
   logic          winner;

   // On a tie, round-robin favours whoever was not served last.
   always_comb begin
      winner = req1;
      if (req0 && req1) begin
         winner = FIXED_PRIO ? 1'b0 : ~last_grant_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      ack0_d       = ack0_q;
      ack1_d       = ack1_q;
      rdata_d      = rdata_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;

      unique case (state_q)
         StIdle: begin
            mem_write_d = 1'b0;
            if (req0 || req1) begin
               state_d      = StAccess;
               grant_id_d   = winner;
               last_grant_d = winner;
               mem_addr_d   = winner ? addr1 : addr0;
               mem_wdata_d  = winner ? wdata1 : wdata0;
               mem_write_d  = winner ? we1 : we0;
            end
         end
         StAccess: begin
            // mem_write_q still reflects the granted transaction's direction here.
            if (!mem_write_q) begin
               rdata_d = mem_rdata;
            end
            mem_write_d = 1'b0;
            ack0_d      = ~grant_id_q;
            ack1_d      = grant_id_q;
            state_d     = StDone;
         end
         StDone: begin
            ack0_d  = 1'b0;
            ack1_d  = 1'b0;
            state_d = StIdle;
         end
         default: begin
            state_d     = StIdle;
            mem_write_d = 1'b0;
            ack0_d      = 1'b0;
            ack1_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata_q      <= '0;
         last_grant_q <= 1'b1;
         grant_id_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         rdata_q      <= rdata_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
      end
   end

   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign rdata     = rdata_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin DUT on a memory model, plus a
// fixed-priority instance checked for starvation of requester 1.
module tb_dmem_arbiter;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1, busy, mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata, rdata;

   logic          fp_req0, fp_req1, fp_we;
   logic [AW-1:0] fp_addr;
   logic [DW-1:0] fp_wdata, fp_mem_rdata;
   logic          fp_ack0, fp_ack1, fp_busy, fp_mem_write;
   logic [AW-1:0] fp_mem_addr;
   logic [DW-1:0] fp_rdata, fp_mem_wdata;

   logic [DW-1:0] mem [32];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
      .rdata(rdata), .busy(busy), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   dmem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b1)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .req0(fp_req0), .we0(fp_we), .addr0(fp_addr), .wdata0(fp_wdata), .ack0(fp_ack0),
      .req1(fp_req1), .we1(fp_we), .addr1(fp_addr), .wdata1(fp_wdata), .ack1(fp_ack1),
      .rdata(fp_rdata), .busy(fp_busy), .mem_write(fp_mem_write), .mem_addr(fp_mem_addr),
      .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata)
   );

   // Memory model: power-up contents, combinational read, write on rising edge.
   assign mem_rdata = mem[mem_addr];
   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 16'(16'h0100 + i);
      mem[0]  = 16'd1;
      mem[3]  = 16'd26;
      mem[4]  = 16'd5;
      mem[5]  = 16'd30;
      mem[6]  = 16'hFFFF;
      mem[9]  = 16'd0;
      mem[10] = 16'd8;
      forever begin
         @(posedge clk);
         if (mem_write) mem[mem_addr] <= mem_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Single-requester transaction, started at a negedge with the DUT idle.
   task automatic xact(input bit who, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int lat, output int wr_cycles,
                       output int other_acks, output logic [AW-1:0] addr_c1);
      if (!who) begin
         req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
      end
      lat = 0; wr_cycles = 0; other_acks = 0; addr_c1 = '0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) addr_c1 = mem_addr;
         if (mem_write) wr_cycles++;
         if (who ? ack0 : ack1) other_acks++;
         if (who ? ack1 : ack0) begin
            lat = c;
            break;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int lat, wr, oth, t0, t1, n, fa0, fa1;
      logic [AW-1:0] a1;
      int seq [6];

      rst_n = 1'b0;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      fp_req0 = 1'b0; fp_req1 = 1'b0; fp_we = 1'b0; fp_addr = 5'd7; fp_wdata = '0;
      fp_mem_rdata = 16'h0000;

      @(negedge clk);
      check("rst busy", 32'(busy), 32'd0);
      check("rst mem_write", 32'(mem_write), 32'd0);
      check("rst mem_addr", 32'(mem_addr), 32'd0);
      check("rst mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst acks", 32'({ack1, ack0}), 32'd0);
      check("rst rdata", 32'(rdata), 32'd0);
      rst_n = 1'b1;

      // Read addr 3 from power-up contents.
      xact(1'b0, 1'b0, 5'd3, 16'h0, lat, wr, oth, a1);
      check("rd3 mem_addr", 32'(a1), 32'd3);
      check("rd3 latency", 32'(lat), 32'd2);
      check("rd3 rdata", 32'(rdata), 32'd26);
      check("rd3 no ack1", 32'(oth), 32'd0);
      check("rd3 no write", 32'(wr), 32'd0);
      check("rd3 idle", 32'(busy), 32'd0);

      // Requester 1 write, then requester 0 reads it back.
      xact(1'b1, 1'b1, 5'd9, 16'h00A5, lat, wr, oth, a1);
      check("wr9 latency", 32'(lat), 32'd2);
      check("wr9 write cycles", 32'(wr), 32'd1);
      check("wr9 no ack0", 32'(oth), 32'd0);
      xact(1'b0, 1'b0, 5'd9, 16'h0, lat, wr, oth, a1);
      check("rd9 latency", 32'(lat), 32'd2);
      check("rd9 rdata", 32'(rdata), 32'h00A5);

      // Simultaneous reads after reset: requester 0 wins the first tie.
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd5;
      req1 = 1'b1; we1 = 1'b0; addr1 = 5'd10;
      t0 = -1; t1 = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (ack0) begin
            t0 = c;
            check("tie rd5 rdata", 32'(rdata), 32'd30);
            req0 = 1'b0;
         end
         if (ack1) begin
            t1 = c;
            check("tie rd10 rdata", 32'(rdata), 32'd8);
            req1 = 1'b0;
         end
         if (t0 >= 0 && t1 >= 0) break;
      end
      req0 = 1'b0; req1 = 1'b0;
      check("tie ack0 time", 32'(t0), 32'd2);
      check("tie ack gap", 32'(t1 - t0), 32'd3);
      @(negedge clk);

      // Both held continuously: grants alternate.
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd1;
      req1 = 1'b1; we1 = 1'b0; addr1 = 5'd2;
      n = 0;
      for (int i = 0; i < 6; i++) seq[i] = 2;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (ack0 && n < 6) begin seq[n] = 0; n++; end
         if (ack1 && n < 6) begin seq[n] = 1; n++; end
         if (n == 6) break;
      end
      req0 = 1'b0; req1 = 1'b0;
      check("rr ack count", 32'(n), 32'd6);
      for (int i = 0; i < 6; i++) check($sformatf("rr grant %0d", i), 32'(seq[i]), 32'(i % 2));
      @(negedge clk);
      @(negedge clk);

      // Fixed priority: requester 1 starves while req0 stays high.
      fp_req0 = 1'b1; fp_req1 = 1'b1;
      fa0 = 0; fa1 = 0;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (fp_ack0) fa0++;
         if (fp_ack1) fa1++;
      end
      fp_req0 = 1'b0; fp_req1 = 1'b0;
      check("fp ack0 count", 32'(fa0), 32'd6);
      check("fp ack1 count", 32'(fa1), 32'd0);
      @(negedge clk);
      @(negedge clk);

      // Reset during a write's ACCESS cycle aborts it.
      req0 = 1'b1; we0 = 1'b1; addr0 = 5'd4; wdata0 = 16'h1234;
      @(negedge clk);
      check("abort in access", 32'(mem_write), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort mem_write", 32'(mem_write), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      check("abort rdata", 32'(rdata), 32'd0);
      req0 = 1'b0;
      @(negedge clk);
      check("abort no ack0", 32'(ack0), 32'd0);
      rst_n = 1'b1;
      xact(1'b0, 1'b0, 5'd4, 16'h0, lat, wr, oth, a1);
      check("abort rd4 latency", 32'(lat), 32'd2);
      check("abort rd4 rdata", 32'(rdata), 32'd5);

      // Address changed after grant; held req starts a second transaction.
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd6;
      @(negedge clk);
      addr0 = 5'd0;
      @(negedge clk);
      check("hold ack0 #1", 32'(ack0), 32'd1);
      check("hold rd6 rdata", 32'(rdata), 32'hFFFF);
      @(negedge clk);
      check("hold idle", 32'(busy), 32'd0);
      @(negedge clk);
      check("hold regrant addr", 32'(mem_addr), 32'd0);
      @(negedge clk);
      check("hold ack0 #2", 32'(ack0), 32'd1);
      check("hold rd0 rdata", 32'(rdata), 32'd1);
      req0 = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer for the 32 x 16-bit data memory. Requester 0 is the processor load/store stage and requester 1 is the loader/debug port. Each transaction is granted, presented to the memory as a registered address, write-data and write-enable set, then completed with a one-cycle ack. Read data is captured from the memory's combinational read output into a holding register.

Parameters:
AW, 5, memory address width (32 words)
DW, 16, data width
FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 transaction request
we0  input  1  requester 0: 1 = write, 0 = read
addr0  input  AW  requester 0 word address
wdata0  input  DW  requester 0 write data
ack0  output  1  one-cycle completion pulse to requester 0
req1  input  1  requester 1 transaction request
we1  input  1  requester 1: 1 = write, 0 = read
addr1  input  AW  requester 1 word address
wdata1  input  DW  requester 1 write data
ack1  output  1  one-cycle completion pulse to requester 1
rdata  output  DW  read data of the last completed read
busy  output  1  high in ACCESS and DONE
mem_write  output  1  to memory write input
mem_addr  output  AW  to memory addr input
mem_wdata  output  DW  to memory datain input
mem_rdata  input  DW  from memory dataout (combinational on mem_addr)

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE
  - mem_write=0, mem_addr=0, mem_wdata=0
  - ack0=ack1=0, rdata=0, busy=0
  - last_grant=1, so requester 0 wins the first tie
- All outputs are registered. No combinational path exists from req/addr to mem_*.
- State machine:
  - IDLE:
    - No req: stay in IDLE, mem_write=0.
    - Any req sampled: select the winner.
      - Only one req high: that requester wins.
      - Both high, FIXED_PRIO=1: requester 0 wins.
      - Both high, FIXED_PRIO=0: the requester not equal to last_grant wins.
    - Latch the winner's addr and wdata into mem_addr and mem_wdata.
    - Drive mem_write=winner's we.
    - Record the winner in grant_id and update last_grant.
    - Next state: ACCESS.
  - ACCESS (one cycle):
    - mem_* are stable for the whole cycle, so the memory commits the write at the edge that ends ACCESS.
    - At that edge:
      - If the transaction is a read, rdata <= mem_rdata. If it is a write, rdata is unchanged.
      - mem_write <= 0.
      - ack[grant_id] <= 1.
    - Next state: DONE.
  - DONE (one cycle): ack high for exactly this cycle. At its end, ack <= 0 and next state is IDLE.
- Latency, with req sampled at edge E1:
  - mem_* valid after E1.
  - Write committed, and rdata valid, at E2.
  - ack high E2..E3.
  - Next request sampled no earlier than E4 (IDLE). Peak rate is one access per 3 cycles.
- Handshake:
  - A requester holds req high until it sees ack.
  - addr, we and wdata are sampled only at the grant edge and may change afterwards.
  - req still high during DONE is ignored. req still high in the following IDLE is treated as a new transaction.
- The losing requester's req stays pending. It is served at the next IDLE unless FIXED_PRIO=1 and req0 is high again.
- Round-robin guarantee (FIXED_PRIO=0): with both reqs held continuously, grants alternate 0,1,0,1.
- Reset mid-transaction:
  - mem_write drops immediately, so no write occurs at the next edge.
  - No ack is issued and rdata returns to 0.
  - Requesters must re-issue.
- mem_addr and mem_wdata hold their last values in IDLE. Only mem_write gates the memory.
- busy = (state != IDLE).

Test Plan:
- Reset, then req0 read addr 3 with the memory at power-up contents -> mem_addr=3 one cycle after grant; ack0 pulses 2 cycles after the request edge; rdata=26; ack1 never asserts.
- req1 write addr 9, wdata 0x00A5 -> mem_write high for exactly one cycle; ack1 pulse; a subsequent req0 read of addr 9 returns rdata=0x00A5.
- req0 and req1 raised together (read addr 5 / read addr 10), held until acked, FIXED_PRIO=0 -> ack0 first with rdata=30, then ack1 with rdata=8; exactly 3 cycles between the ack0 and ack1 pulses.
- Both reqs held continuously for 6 transactions -> grant order 0,1,0,1,0,1. With FIXED_PRIO=1 -> requester 1 is never acked while req0 stays high.
- req0 write addr 4, wdata 0x1234, and rst_n pulled low during ACCESS before the clock edge -> mem_write=0 immediately; after reset, a read of addr 4 returns 5 (unchanged); no ack0.
- req0 read addr 6, with req0 kept high and addr changed to 0 after the grant edge -> rdata=0xFFFF (the latched address is used); ack0 pulse; a new transaction is granted in the following IDLE reading addr 0 -> rdata=1.
